// File: rtl/fp24_inv_sqrt_arbiter_pkg.sv
// Shared math types for the fp24 inverse-square-root pipeline and the arbiter that feeds it.
package fp24_inv_sqrt_arbiter_pkg;

  // fp24: sign, 7-bit exponent (bias 63), 16-bit fraction.
  typedef logic [23:0] fp24_t;

  localparam int FP24_INV_SQRT_LATENCY = 18;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp24_inv_sqrt_arbiter_if.sv
// Requester, shared-pipeline and response signals of the fp24 inverse-sqrt arbiter.
interface fp24_inv_sqrt_arbiter_if
  import fp24_inv_sqrt_arbiter_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 8
);
  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // An operand transfers in any cycle where req_valid[i] and req_ready[i] are both high;
  // req_ready may depend combinationally on req_valid. resp_valid is a one-cycle strobe
  // with no backpressure, and resp_data is meaningful only while it is high.
  logic [N_REQ-1:0]            req_valid;
  fp24_t [N_REQ-1:0]           req_x;
  logic [N_REQ-1:0]            req_ready;
  fp24_t                       sq_x;
  logic                        sq_x_valid;
  fp24_t                       sq_result;
  logic [N_REQ-1:0]            resp_valid;
  fp24_t                       resp_data;
  logic                        busy;
  logic [ID_W-1:0]             dbg_rr_ptr;
  logic [N_REQ-1:0][CNT_W-1:0] dbg_count;

  modport master (
    output req_valid, req_x, sq_result,
    input  req_ready, sq_x, sq_x_valid, resp_valid, resp_data, busy, dbg_rr_ptr, dbg_count
  );

  modport slave (
    input  req_valid, req_x, sq_result,
    output req_ready, sq_x, sq_x_valid, resp_valid, resp_data, busy, dbg_rr_ptr, dbg_count
  );

endinterface

// File: rtl/fp24_inv_sqrt_arbiter_rr_arbiter.sv
// Round-robin pick: masks requests by availability, then searches upward from ptr with wrap.
module fp24_inv_sqrt_arbiter_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] avail,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid
);

  logic [N_REQ-1:0] cand;

  assign cand = req & avail;

  always_comb begin
    int              sum;
    logic [ID_W-1:0] idx;
    sum         = 0;
    idx         = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = ID_W'(sum);
      if (!grant_valid && cand[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp24_inv_sqrt_arbiter.sv
// Shares one fixed-latency fp24 inverse-sqrt pipeline among N_REQ requesters; a tag shift
// register matching the pipeline depth routes each result back to its requester.
module fp24_inv_sqrt_arbiter
  import fp24_inv_sqrt_arbiter_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int LATENCY         = FP24_INV_SQRT_LATENCY,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic                   clk,
  input logic                   rst,
  fp24_inv_sqrt_arbiter_if.slave bus
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  tag_t [LATENCY-1:0]          tags;
  tag_t                        exit_tag;
  logic [ID_W-1:0]             rr_ptr;
  logic [N_REQ-1:0][CNT_W-1:0] count;
  logic [N_REQ-1:0]            retire;
  logic [N_REQ-1:0]            avail;
  logic [N_REQ-1:0]            grant;
  logic [ID_W-1:0]             grant_idx;
  logic                        grant_valid;
  logic                        busy_c;

  assign exit_tag = tags[LATENCY-1];

  always_comb begin
    retire = '0;
    if (exit_tag.valid) retire[exit_tag.id] = 1'b1;
  end

  // A requester at its cap stays eligible in the cycle one of its results retires.
  always_comb begin
    avail = '0;
    for (int i = 0; i < N_REQ; i++) begin
      avail[i] = (count[i] != CNT_W'(MAX_OUTSTANDING)) || retire[i];
    end
  end

  fp24_inv_sqrt_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req         (bus.req_valid & {N_REQ{rst}}),
    .avail       (avail),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k < LATENCY; k++) busy_c = busy_c | tags[k].valid;
  end

  assign bus.req_ready  = grant;
  assign bus.sq_x_valid = grant_valid;
  assign bus.sq_x       = grant_valid ? bus.req_x[grant_idx] : '0;
  assign bus.resp_valid = retire;
  assign bus.resp_data  = exit_tag.valid ? bus.sq_result : '0;
  assign bus.busy       = busy_c;
  assign bus.dbg_rr_ptr = rr_ptr;
  assign bus.dbg_count  = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      tags   <= '0;
      count  <= '0;
    end else begin
      if (grant_valid) begin
        rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      tags <= {tags[LATENCY-2:0], tag_t'{valid: grant_valid, id: grant_idx}};
      for (int i = 0; i < N_REQ; i++) begin
        case ({grant[i], retire[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp24_inv_sqrt_arbiter.sv
// Directed bench for the fp24 inverse-sqrt arbiter with a stand-in 18-cycle pipeline.
module tb_fp24_inv_sqrt_arbiter;
  import fp24_inv_sqrt_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int LAT  = 18;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp24_inv_sqrt_arbiter_if #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) bus ();

  fp24_inv_sqrt_arbiter #(
    .N_REQ           (N),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Stand-in results: exact values for the operands used here, bit-inverted otherwise.
  function automatic fp24_t model_f(input fp24_t x);
    fp24_t r;
    case (x)
      24'h410000: r = 24'h3E0000;
      24'h3F0000: r = 24'h3F0000;
      24'h400000: r = 24'h3E6A0A;
      24'h420000: r = 24'h3D6A0A;
      default:    r = ~x;
    endcase
    return r;
  endfunction

  // Stand-in pipeline keeps running through reset, like the real one.
  fp24_t pipe [LAT];
  initial for (int k = 0; k < LAT; k++) pipe[k] = '0;
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= bus.sq_x_valid ? model_f(bus.sq_x) : '0;
  end
  assign bus.sq_result = pipe[LAT-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  // {due_cycle[31:0], id[1:0], data[23:0]}
  logic [57:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: inputs already driven; checks the cycle's outputs against hand-given ready.
  task automatic step(input logic [N-1:0] exp_ready);
    logic [N-1:0] exp_resp;
    fp24_t        exp_data;
    fp24_t        exp_sqx;
    logic [57:0]  e;
    @(negedge clk);
    if (!rst) exp_q.delete();
    exp_resp = '0;
    exp_data = '0;
    chk("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
    while (exp_q.size() != 0 && exp_q[0][57:26] < 32'(cyc)) begin
      e = exp_q.pop_front();
      chk("resp_missed_due", 32'(cyc), e[57:26]);
    end
    if (exp_q.size() != 0 && exp_q[0][57:26] == 32'(cyc)) begin
      e = exp_q.pop_front();
      exp_resp[e[25:24]] = 1'b1;
      exp_data = e[23:0];
    end
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_resp));
    if (exp_resp != '0 || !rst) chk("resp_data", 32'(bus.resp_data), 32'(exp_data));
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    exp_sqx = '0;
    for (int i = 0; i < N; i++) if (exp_ready[i]) exp_sqx = bus.req_x[i];
    chk("sq_x_valid", 32'(bus.sq_x_valid), 32'(exp_ready != '0));
    chk("sq_x", 32'(bus.sq_x), 32'(exp_sqx));
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        if (exp_ready[i] && bus.req_valid[i])
          exp_q.push_back({32'(cyc + LAT), 2'(i), model_f(bus.req_x[i])});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.req_valid = '1;
    repeat (n) step('0);
    chk("rst_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
    chk("rst_count", 32'(bus.dbg_count), 32'd0);
    bus.req_valid = '0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_x = {24'h420000, 24'h3F0000, 24'h410000, 24'h400000};

    // Reset state with all requesters asserting valid.
    do_reset(3);

    // Single request: 4.0 -> 0.5, granted same cycle, response 18 cycles later.
    bus.req_valid = 4'b0001;
    bus.req_x[0] = 24'h410000;
    step(4'b0001);
    bus.req_valid = '0;
    chk("rr_ptr_after_g0", 32'(bus.dbg_rr_ptr), 32'd1);
    repeat (20) step('0);

    // All four valid from rr_ptr=0: grants rotate 0,1,2,3 and responses follow the same order.
    do_reset(2);
    bus.req_x = {24'h420000, 24'h3F0000, 24'h410000, 24'h400000};
    bus.req_valid = 4'b1111;
    repeat (3) begin
      step(4'b0001);
      step(4'b0010);
      step(4'b0100);
      step(4'b1000);
    end
    bus.req_valid = '0;
    repeat (24) step('0);

    // Requester 2 holds valid for 9 ops: 8 accepted, 9th in the cycle the first retires.
    bus.req_valid = 4'b0100;
    bus.req_x[2] = 24'h3F0000;
    repeat (8) step(4'b0100);
    chk("count_at_cap", 32'(bus.dbg_count[2]), 32'd8);
    repeat (10) step('0);
    step(4'b0100);
    bus.req_valid = '0;
    chk("count_grant_retire", 32'(bus.dbg_count[2]), 32'd8);
    repeat (20) step('0);
    chk("count_drained", 32'(bus.dbg_count[2]), 32'd0);

    // Bubbles: accepts at relative cycles 0, 3, 4.
    bus.req_x[1] = 24'h400000;
    bus.req_valid = 4'b0010;
    step(4'b0010);
    bus.req_valid = '0;
    step('0);
    step('0);
    bus.req_valid = 4'b0010;
    step(4'b0010);
    step(4'b0010);
    bus.req_valid = '0;
    repeat (20) step('0);

    // Reset at relative cycle 10 with 5 in flight; new request at 12 returns at 30 only.
    bus.req_x[3] = 24'h420000;
    bus.req_valid = 4'b1000;
    repeat (5) step(4'b1000);
    bus.req_valid = '0;
    repeat (5) step('0);
    do_reset(2);
    bus.req_x[1] = 24'h3F0000;
    bus.req_valid = 4'b0010;
    step(4'b0010);
    bus.req_valid = '0;
    repeat (29) step('0);

    // Wrap: rr_ptr=2 with requesters 0 and 1 valid picks 0, then 1, then 0 again.
    chk("rr_ptr_before_wrap", 32'(bus.dbg_rr_ptr), 32'd2);
    bus.req_x[0] = 24'h410000;
    bus.req_x[1] = 24'h400000;
    bus.req_valid = 4'b0011;
    step(4'b0001);
    chk("rr_ptr_after_wrap", 32'(bus.dbg_rr_ptr), 32'd1);
    step(4'b0010);
    step(4'b0001);
    bus.req_valid = '0;
    repeat (20) step('0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
